// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcodes, state encoding and IR field positions for cpu_control_unit
package cpu_ctrl_pkg;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_OR   = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T1W, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  // Instruction families that share a microstep sequence
  typedef enum logic [3:0] {
    CL_ALU, CL_MULDIV, CL_UNARY, CL_IMM, CL_LD, CL_ST,
    CL_MFHI, CL_MFLO, CL_IN, CL_OUT, CL_HALT, CL_NOP
  } op_class_t;

  function automatic op_class_t classify(input logic [4:0] op);
    op_class_t cls;
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_OR, OP_AND:   cls = CL_ALU;
      OP_MUL, OP_DIV:                  cls = CL_MULDIV;
      OP_NEG, OP_NOT:                  cls = CL_UNARY;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: cls = CL_IMM;
      OP_LD:                           cls = CL_LD;
      OP_ST:                           cls = CL_ST;
      OP_MFHI:                         cls = CL_MFHI;
      OP_MFLO:                         cls = CL_MFLO;
      OP_IN:                           cls = CL_IN;
      OP_OUT:                          cls = CL_OUT;
      OP_HALT:                         cls = CL_HALT;
      OP_NOP:                          cls = CL_NOP;
      default:                         cls = CL_NOP;
    endcase
    return cls;
  endfunction

  // Immediate forms and address calculations reuse the plain ALU operation
  function automatic logic [4:0] alu_select(input logic [4:0] op);
    logic [4:0] sel;
    case (op)
      OP_ANDI:                        sel = OP_AND;
      OP_ORI:                         sel = OP_OR;
      OP_ADDI, OP_LDI, OP_LD, OP_ST:  sel = OP_ADD;
      default:                        sel = op;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// rtl/cpu_control_unit_if.sv - control unit <-> datapath strobe bundle
interface cpu_control_unit_if #(
  parameter int NUM_REGS = 16,
  parameter int OPW      = 5
);
  logic [31:0]         ir;
  logic                mem_rdy;
  logic [NUM_REGS-1:0] reg_in;
  logic [NUM_REGS-1:0] reg_out;
  logic BAout, PCout, PCin, incPC, MARin, MDRin, MDRout, IRin, Yin, Zin;
  logic ZLowOut, ZHighOut, HIin, LOin, HIout, LOout, Cout, InPortOut, OutPortin;
  logic Read, Write;
  logic [OPW-1:0]      opcode;
  logic                run;

  modport master (
    input  ir, mem_rdy,
    output reg_in, reg_out, BAout, PCout, PCin, incPC, MARin, MDRin, MDRout, IRin,
           Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, HIout, LOout, Cout, InPortOut,
           OutPortin, Read, Write, opcode, run
  );

  modport slave (
    output ir, mem_rdy,
    input  reg_in, reg_out, BAout, PCout, PCin, incPC, MARin, MDRin, MDRout, IRin,
           Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, HIout, LOout, Cout, InPortOut,
           OutPortin, Read, Write, opcode, run
  );
endinterface

// File: rtl/cpu_control_unit_ir_reg_select.sv
// rtl/cpu_control_unit_ir_reg_select.sv - IR register field to one-hot reg_in/reg_out/BAout
module ir_reg_select #(
  parameter int NUM_REGS = 16
) (
  input  logic [3:0]          ra,
  input  logic [3:0]          rb,
  input  logic [3:0]          rc,
  input  logic                gra,
  input  logic                grb,
  input  logic                grc,
  input  logic                rin,
  input  logic                rout,
  input  logic                ba,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                ba_out
);
  logic [3:0]          sel;
  logic [NUM_REGS-1:0] one_hot;
  logic                base;

  // Pick the requested field, then expand; R0 as a base register drives zero instead
  always_comb begin
    sel = 4'd0;
    if (gra)      sel = ra;
    else if (grb) sel = rb;
    else if (grc) sel = rc;
    one_hot = NUM_REGS'(1) << sel;
    base    = ba && (sel == 4'd0);
    ba_out  = rout && base;
    reg_out = (rout && !base) ? one_hot : '0;
    reg_in  = rin ? one_hot : '0;
  end
endmodule

// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - multi-cycle control FSM; optional INSTR_COUNT_EN adds instr_count
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OPW      = 5
) (
  input logic clk,
  input logic clr,
  cpu_control_unit_if.master bus
`ifdef INSTR_COUNT_EN
  , output logic [31:0] instr_count
`endif
);
  state_t              state, next_state;
  op_class_t           cls;
  logic [4:0]          op;
  logic                gra, grb, grc, rin, rout, ba;
  logic [NUM_REGS-1:0] sel_reg_in, sel_reg_out;
  logic                sel_ba_out;
  logic                unused_ir;

  assign op        = bus.ir[OP_HI:OP_LO];
  assign cls       = classify(op);
  assign unused_ir = ^bus.ir[RC_LO-1:0];

  // Sequencing: fetch, decode, then the family-specific microsteps
  always_comb begin
    next_state = state;
    case (state)
      ST_RST:        next_state = ST_T0;
      ST_T0:         next_state = ST_T1;
      ST_T1, ST_T1W: next_state = bus.mem_rdy ? ST_T2 : ST_T1W;
      ST_T2:         next_state = ST_T3;
      ST_T3: begin
        if (cls == CL_HALT) next_state = ST_HALT;
        else if (cls inside {CL_ALU, CL_MULDIV, CL_UNARY, CL_IMM, CL_LD, CL_ST})
          next_state = ST_T4;
        else next_state = ST_T0;
      end
      ST_T4:   next_state = (cls == CL_UNARY) ? ST_T0 : ST_T5;
      ST_T5:   next_state = (cls inside {CL_MULDIV, CL_LD, CL_ST}) ? ST_T6 : ST_T0;
      ST_T6: begin
        if (cls == CL_ST)      next_state = ST_T7;
        else if (cls == CL_LD) next_state = bus.mem_rdy ? ST_T7 : ST_T6;
        else                   next_state = ST_T0;
      end
      ST_T7:   next_state = (cls == CL_ST && !bus.mem_rdy) ? ST_T7 : ST_T0;
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_RST;
    endcase
  end

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= ST_RST;
    else      state <= next_state;
  end

  // Moore strobe decode from the state register and the IR
  always_comb begin
    {bus.PCout, bus.PCin, bus.incPC, bus.MARin, bus.MDRin, bus.MDRout, bus.IRin} = '0;
    {bus.Yin, bus.Zin, bus.ZLowOut, bus.ZHighOut, bus.HIin, bus.LOin} = '0;
    {bus.HIout, bus.LOout, bus.Cout, bus.InPortOut, bus.OutPortin} = '0;
    {bus.Read, bus.Write} = '0;
    {gra, grb, grc, rin, rout, ba} = '0;
    bus.opcode = '0;
    bus.run    = (state != ST_HALT);
    case (state)
      ST_T0:  {bus.PCout, bus.MARin, bus.incPC, bus.Zin} = '1;
      ST_T1:  {bus.ZLowOut, bus.PCin, bus.Read, bus.MDRin} = '1;
      ST_T1W: {bus.Read, bus.MDRin} = '1;
      ST_T2:  {bus.MDRout, bus.IRin} = '1;
      ST_T3: begin
        case (cls)
          CL_ALU, CL_MULDIV:   {grb, rout, bus.Yin} = '1;
          CL_UNARY: begin
            {grb, rout, bus.Zin} = '1;
            bus.opcode = OPW'(op);
          end
          CL_IMM, CL_LD, CL_ST: {grb, rout, ba, bus.Yin} = '1;
          CL_MFHI: {bus.HIout, gra, rin} = '1;
          CL_MFLO: {bus.LOout, gra, rin} = '1;
          CL_IN:   {bus.InPortOut, gra, rin} = '1;
          CL_OUT:  {gra, rout, bus.OutPortin} = '1;
          default: ;
        endcase
      end
      ST_T4: begin
        case (cls)
          CL_ALU, CL_MULDIV: begin
            {grc, rout, bus.Zin} = '1;
            bus.opcode = OPW'(op);
          end
          CL_UNARY: {bus.ZLowOut, gra, rin} = '1;
          CL_IMM, CL_LD, CL_ST: begin
            {bus.Cout, bus.Zin} = '1;
            bus.opcode = OPW'(alu_select(op));
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (cls)
          CL_ALU, CL_IMM: {bus.ZLowOut, gra, rin} = '1;
          CL_MULDIV:      {bus.ZLowOut, bus.LOin} = '1;
          CL_LD, CL_ST:   {bus.ZLowOut, bus.MARin} = '1;
          default: ;
        endcase
      end
      ST_T6: begin
        case (cls)
          CL_MULDIV: {bus.ZHighOut, bus.HIin} = '1;
          CL_LD:     {bus.Read, bus.MDRin} = '1;
          CL_ST:     {gra, rout, bus.MDRin} = '1;
          default: ;
        endcase
      end
      ST_T7: begin
        if (cls == CL_LD)      {bus.MDRout, gra, rin} = '1;
        else if (cls == CL_ST) bus.Write = 1'b1;
      end
      default: ;
    endcase
  end

  ir_reg_select #(.NUM_REGS(NUM_REGS)) u_reg_select (
    .ra      (bus.ir[RA_HI:RA_LO]),
    .rb      (bus.ir[RB_HI:RB_LO]),
    .rc      (bus.ir[RC_HI:RC_LO]),
    .gra     (gra),
    .grb     (grb),
    .grc     (grc),
    .rin     (rin),
    .rout    (rout),
    .ba      (ba),
    .reg_in  (sel_reg_in),
    .reg_out (sel_reg_out),
    .ba_out  (sel_ba_out)
  );

  assign bus.reg_in  = sel_reg_in;
  assign bus.reg_out = sel_reg_out;
  assign bus.BAout   = sel_ba_out;

`ifdef INSTR_COUNT_EN
  logic retire;
  assign retire = (next_state == ST_T0) && (state != ST_RST);

  // Retired-instruction counter; HALT never returns to T0 so it freezes there
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)        instr_count <= '0;
    else if (retire) instr_count <= instr_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - directed strobe-sequence bench for cpu_control_unit
module tb_cpu_control_unit;
  logic clk;
  logic clr;
  int   checks   = 0;
  int   failures = 0;
  int   pcin_cnt = 0;
  int   inc_cnt  = 0;

  localparam logic [20:0] S_PCOUT  = 21'(1) << 0;
  localparam logic [20:0] S_PCIN   = 21'(1) << 1;
  localparam logic [20:0] S_INCPC  = 21'(1) << 2;
  localparam logic [20:0] S_MARIN  = 21'(1) << 3;
  localparam logic [20:0] S_MDRIN  = 21'(1) << 4;
  localparam logic [20:0] S_MDROUT = 21'(1) << 5;
  localparam logic [20:0] S_IRIN   = 21'(1) << 6;
  localparam logic [20:0] S_YIN    = 21'(1) << 7;
  localparam logic [20:0] S_ZIN    = 21'(1) << 8;
  localparam logic [20:0] S_ZLOW   = 21'(1) << 9;
  localparam logic [20:0] S_ZHIGH  = 21'(1) << 10;
  localparam logic [20:0] S_HIIN   = 21'(1) << 11;
  localparam logic [20:0] S_LOIN   = 21'(1) << 12;
  localparam logic [20:0] S_HIOUT  = 21'(1) << 13;
  localparam logic [20:0] S_LOOUT  = 21'(1) << 14;
  localparam logic [20:0] S_COUT   = 21'(1) << 15;
  localparam logic [20:0] S_INPORT = 21'(1) << 16;
  localparam logic [20:0] S_OUTPRT = 21'(1) << 17;
  localparam logic [20:0] S_READ   = 21'(1) << 18;
  localparam logic [20:0] S_WRITE  = 21'(1) << 19;
  localparam logic [20:0] S_BAOUT  = 21'(1) << 20;
  localparam logic [20:0] S_NONE   = 21'(0);

  cpu_control_unit_if #(.NUM_REGS(16), .OPW(5)) bus ();

`ifdef INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif

  cpu_control_unit #(.NUM_REGS(16), .OPW(5)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
`ifdef INSTR_COUNT_EN
    , .instr_count (instr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [58:0] snap();
    return {bus.run, bus.opcode, bus.reg_in, bus.reg_out,
            bus.BAout, bus.Write, bus.Read, bus.OutPortin, bus.InPortOut, bus.Cout,
            bus.LOout, bus.HIout, bus.LOin, bus.HIin, bus.ZHighOut, bus.ZLowOut,
            bus.Zin, bus.Yin, bus.IRin, bus.MDRout, bus.MDRin, bus.MARin,
            bus.incPC, bus.PCin, bus.PCout};
  endfunction

  // Check one state cycle, then advance to just after the next posedge
  task automatic step(input string tag, input logic [20:0] s, input logic [15:0] rin,
                      input logic [15:0] rout, input logic [4:0] op, input logic run);
    #1;
    check(tag, 64'(snap()), 64'({run, op, rin, rout, s}));
    if (bus.PCin)  pcin_cnt++;
    if (bus.incPC) inc_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] instr);
    bus.ir = instr;
    step("t0", S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 16'h0, 16'h0, 5'd0, 1'b1);
    step("t1", S_ZLOW | S_PCIN | S_READ | S_MDRIN, 16'h0, 16'h0, 5'd0, 1'b1);
    step("t2", S_MDROUT | S_IRIN, 16'h0, 16'h0, 5'd0, 1'b1);
  endtask

  initial begin
    clr         = 1'b0;
    bus.ir      = 32'h0;
    bus.mem_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 64'(snap()), 64'({1'b1, 58'h0}));
`ifdef INSTR_COUNT_EN
    check("cnt_reset", 64'(instr_count), 64'd0);
`endif
    #3 clr = 1'b1;
    @(posedge clk);
    #1;

    // and R1,R2,R3
    fetch({5'b01010, 4'd1, 4'd2, 4'd3, 15'd0});
    step("and_t3", S_YIN, 16'h0, 16'h0004, 5'd0, 1'b1);
    step("and_t4", S_ZIN, 16'h0, 16'h0008, 5'b01010, 1'b1);
    step("and_t5", S_ZLOW, 16'h0002, 16'h0, 5'd0, 1'b1);

    // nop fetched with memory stalling three cycles in T1
    pcin_cnt = 0;
    inc_cnt  = 0;
    bus.ir = {5'b11010, 27'd0};
    step("w_t0", S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 16'h0, 16'h0, 5'd0, 1'b1);
    bus.mem_rdy = 1'b0;
    step("w_t1", S_ZLOW | S_PCIN | S_READ | S_MDRIN, 16'h0, 16'h0, 5'd0, 1'b1);
    step("w_t1w_a", S_READ | S_MDRIN, 16'h0, 16'h0, 5'd0, 1'b1);
    step("w_t1w_b", S_READ | S_MDRIN, 16'h0, 16'h0, 5'd0, 1'b1);
    bus.mem_rdy = 1'b1;
    step("w_t1w_c", S_READ | S_MDRIN, 16'h0, 16'h0, 5'd0, 1'b1);
    step("w_t2", S_MDROUT | S_IRIN, 16'h0, 16'h0, 5'd0, 1'b1);
    check("w_pcin_once", 64'(pcin_cnt), 64'd1);
    check("w_incpc_once", 64'(inc_cnt), 64'd1);
    step("nop_t3", S_NONE, 16'h0, 16'h0, 5'd0, 1'b1);

    // ld R4,0x10(R0)
    fetch({5'b00000, 4'd4, 4'd0, 19'h10});
    step("ld_t3", S_BAOUT | S_YIN, 16'h0, 16'h0, 5'd0, 1'b1);
    step("ld_t4", S_COUT | S_ZIN, 16'h0, 16'h0, 5'b00011, 1'b1);
    step("ld_t5", S_ZLOW | S_MARIN, 16'h0, 16'h0, 5'd0, 1'b1);
    bus.mem_rdy = 1'b0;
    step("ld_t6_a", S_READ | S_MDRIN, 16'h0, 16'h0, 5'd0, 1'b1);
    step("ld_t6_b", S_READ | S_MDRIN, 16'h0, 16'h0, 5'd0, 1'b1);
    bus.mem_rdy = 1'b1;
    step("ld_t6_c", S_READ | S_MDRIN, 16'h0, 16'h0, 5'd0, 1'b1);
    step("ld_t7", S_MDROUT, 16'h0010, 16'h0, 5'd0, 1'b1);
`ifdef INSTR_COUNT_EN
    #1 check("cnt_three", 64'(instr_count), 64'd3);
    #0;
`endif

    // div R5,R6 (Ra field 0, untouched)
    fetch({5'b01111, 4'd0, 4'd5, 4'd6, 15'd0});
    step("div_t3", S_YIN, 16'h0, 16'h0020, 5'd0, 1'b1);
    step("div_t4", S_ZIN, 16'h0, 16'h0040, 5'b01111, 1'b1);
    step("div_t5", S_ZLOW | S_LOIN, 16'h0, 16'h0, 5'd0, 1'b1);
    step("div_t6", S_ZHIGH | S_HIIN, 16'h0, 16'h0, 5'd0, 1'b1);

    // st R7,3(R2)
    fetch({5'b00010, 4'd7, 4'd2, 19'd3});
    step("st_t3", S_YIN, 16'h0, 16'h0004, 5'd0, 1'b1);
    step("st_t4", S_COUT | S_ZIN, 16'h0, 16'h0, 5'b00011, 1'b1);
    step("st_t5", S_ZLOW | S_MARIN, 16'h0, 16'h0, 5'd0, 1'b1);
    bus.mem_rdy = 1'b0;
    step("st_t6", S_MDRIN, 16'h0, 16'h0080, 5'd0, 1'b1);
    step("st_t7_a", S_WRITE, 16'h0, 16'h0, 5'd0, 1'b1);
    bus.mem_rdy = 1'b1;
    step("st_t7_b", S_WRITE, 16'h0, 16'h0, 5'd0, 1'b1);

    // ori R3,R0,5
    fetch({5'b01101, 4'd3, 4'd0, 19'd5});
    step("ori_t3", S_BAOUT | S_YIN, 16'h0, 16'h0, 5'd0, 1'b1);
    step("ori_t4", S_COUT | S_ZIN, 16'h0, 16'h0, 5'b01001, 1'b1);
    step("ori_t5", S_ZLOW, 16'h0008, 16'h0, 5'd0, 1'b1);

    // mflo R9
    fetch({5'b11001, 4'd9, 23'd0});
    step("mflo_t3", S_LOOUT, 16'h0200, 16'h0, 5'd0, 1'b1);

    // halt, then a reset pulse mid-HALT
    fetch({5'b11011, 27'd0});
    step("halt_t3", S_NONE, 16'h0, 16'h0, 5'd0, 1'b1);
    step("halt_a", S_NONE, 16'h0, 16'h0, 5'd0, 1'b0);
    step("halt_b", S_NONE, 16'h0, 16'h0, 5'd0, 1'b0);
`ifdef INSTR_COUNT_EN
    check("cnt_frozen", 64'(instr_count), 64'd7);
`endif
    clr = 1'b0;
    #1 check("clr_mid_halt", 64'(snap()), 64'({1'b1, 58'h0}));
`ifdef INSTR_COUNT_EN
    check("cnt_cleared", 64'(instr_count), 64'd0);
`endif
    #2 clr = 1'b1;
    @(posedge clk);
    #1;
    bus.ir = 32'h0;
    step("restart_t0", S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 16'h0, 16'h0, 5'd0, 1'b1);
    step("restart_t1", S_ZLOW | S_PCIN | S_READ | S_MDRIN, 16'h0, 16'h0, 5'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
